// File: rtl/ysyx_22050133_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state type and the word-result sign-extension helper.
package ysyx_22050133_mdu_pkg;

  // Operation encoding (matches funct3 of the RV M extension)
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign-extend the low 32 bits of x to 64 bits.
  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_22050133_mdu_negate.sv
// Conditional two's-complement: y = en ? -x : x.
module ysyx_22050133_mdu_negate #(
  parameter int W = 64
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign y = en ? (~x + ONE) : x;

endmodule

// File: rtl/ysyx_22050133_mdu.sv
// Iterative multiply/divide unit: one shared shift-add / restoring-division
// datapath on a single 2*XLEN+1 accumulator, one result bit per CALC cycle,
// plus one final cycle for sign correction and word sign-extension.
//
// Handshake: a request is taken on a rising clk edge when in_valid && in_ready
// && !flush (in_ready is high only in IDLE); a result is presented with
// out_valid held high and result stable until a rising edge sees out_ready,
// after which the unit is back in IDLE. flush wins over both handshakes.
module ysyx_22050133_mdu
  import ysyx_22050133_mdu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int AW = 2 * XLEN + 1;
  localparam logic [CW-1:0]   CNT_FULL  = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_WORD  = CW'(32);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] HALF_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] HALF_WORD = XLEN'(32'h8000_0000);

  // Narrow x to its low word, sign- or zero-extended back to XLEN.
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sgn);
    logic [63:0] wide;
    wide = sgn ? sext32(64'(x)) : {32'd0, x[31:0]};
    return wide[XLEN-1:0];
  endfunction

  state_t state_q, state_d;

  logic [2:0]      op_q;
  logic            word_q;
  logic            s1_q, s2_q;
  logic [XLEN-1:0] opa_q, opb_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            sgn1_in, sgn2_in, neg1_in, neg2_in;
  logic [XLEN-1:0] src1_ext, src2_ext, a_abs, b_abs;
  logic [CW-1:0]   cnt_in;

  logic            is_mul, is_rem, first, fin;
  logic            a_zero, b_zero, ovf, special;
  logic [CW-1:0]   cnt_n;
  logic [XLEN:0]   mul_sum, div_tmp, div_sub;
  logic            div_ge;
  logic [AW-1:0]   mul_next, div_next, early_acc;
  logic [2*XLEN-1:0] prod;
  logic              fix_en, neg_en;
  logic [2*XLEN-1:0] fix_x, neg_x, neg_y;
  logic [XLEN-1:0]   res_raw, res_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; flush forces IDLE from any state
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign accept = (state_q == IDLE) && in_valid && !flush;

  // Operand conditioning for the accept cycle: word narrowing and sign flags
  always_comb begin
    sgn1_in  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn2_in  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    src1_ext = word ? ext32(src1, sgn1_in) : src1;
    src2_ext = word ? ext32(src2, sgn2_in) : src2;
    neg1_in  = sgn1_in && src1_ext[XLEN-1];
    neg2_in  = sgn2_in && src2_ext[XLEN-1];
    cnt_in   = word ? CNT_WORD : CNT_FULL;
  end

  // Per-cycle iteration step, special-case detection and result selection
  always_comb begin
    is_mul  = !op_q[2];
    is_rem  = (op_q == OP_REM) || (op_q == OP_REMU);
    cnt_n   = word_q ? CNT_WORD : CNT_FULL;
    first   = (cnt_q == cnt_n);
    fin     = (state_q == CALC) && (cnt_q == '0);
    a_zero  = (opa_q == '0);
    b_zero  = (opb_q == '0);
    // Only signed ops can have both sign flags set.
    ovf     = !is_mul && s1_q && s2_q && (opb_q == ONE) &&
              (opa_q == (word_q ? HALF_WORD : HALF_FULL));
    special = is_mul ? (a_zero || b_zero) : (b_zero || ovf);

    // Multiply: add multiplicand into the high half when the low bit is set,
    // then shift the whole accumulator right.
    mul_sum  = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};

    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor when it fits; the quotient bit enters at the bottom.
    div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = (div_tmp >= {1'b0, opb_q});
    div_sub  = div_tmp - {1'b0, opb_q};
    div_next = {(div_ge ? div_sub : div_tmp), acc_q[XLEN-2:0], div_ge};

    // Accumulator contents that the full iteration would have produced.
    if (is_mul)      early_acc = '0;
    else if (b_zero) early_acc = {1'b0, opa_q, {XLEN{1'b1}}};
    else             early_acc = {{(XLEN+1){1'b0}}, opa_q};

    // A word multiply runs 32 steps, leaving the product 32 bits up.
    prod = acc_q[2*XLEN-1:0] >> (word_q ? (XLEN - 32) : 0);

    // Quotient sign is suppressed on divide-by-zero so the result stays all ones.
    if (is_mul) begin
      fix_en = s1_q ^ s2_q;
      fix_x  = prod;
    end else if (is_rem) begin
      fix_en = s1_q;
      fix_x  = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    end else begin
      fix_en = (s1_q ^ s2_q) && !b_zero;
      fix_x  = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
    end
  end

  // The wide negator takes |src2| while idle and fixes the result sign at the end.
  always_comb begin
    neg_en = fin ? fix_en : neg2_in;
    neg_x  = fin ? fix_x : {{XLEN{1'b0}}, src2_ext};
  end

  ysyx_22050133_mdu_negate #(.W(XLEN)) u_neg_abs (
    .en (neg1_in),
    .x  (src1_ext),
    .y  (a_abs)
  );

  ysyx_22050133_mdu_negate #(.W(2*XLEN)) u_neg_fix (
    .en (neg_en),
    .x  (neg_x),
    .y  (neg_y)
  );

  assign b_abs   = neg_y[XLEN-1:0];
  assign res_raw = (is_mul && (op_q != OP_MUL)) ? neg_y[2*XLEN-1:XLEN] : neg_y[XLEN-1:0];
  assign res_d   = word_q ? ext32(res_raw, 1'b1) : res_raw;

  // Datapath: latch operands on accept, iterate in CALC, register the result
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      word_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= op;
      word_q <= word;
      s1_q   <= neg1_in;
      s2_q   <= neg2_in;
      opa_q  <= a_abs;
      opb_q  <= b_abs;
      cnt_q  <= cnt_in;
      if (op[2]) acc_q <= {{(XLEN+1){1'b0}}, (a_abs << (word ? (XLEN - 32) : 0))};
      else       acc_q <= {{(XLEN+1){1'b0}}, b_abs};
    end else if ((state_q == CALC) && !flush) begin
      if (cnt_q != '0) begin
        if (EARLY_OUT && first && special) begin
          acc_q <= early_acc;
          cnt_q <= '0;
        end else begin
          acc_q <= is_mul ? mul_next : div_next;
          cnt_q <= cnt_q - CNT_ONE;
        end
      end else begin
        result_q <= res_d;
      end
    end
  end

  assign result = result_q;

endmodule
